// File: rtl/if_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface if_stage_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, imem req/ack fetch, IF/ID register with freeze and branch flush.
// Optional IF_PERF_CNT_EN adds fetch_count / stall_count performance counters.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        freeze,
    input  logic        branch_taken,
    input  logic [31:0] branch_addr,
    if_stage_if.master  imem,
    output logic [31:0] pc_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_count
`endif
);

    typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;

    state_t      state;
    logic        req;
    logic [31:0] pc;
    logic [31:0] target;
    logic [31:0] hold_word;
    logic [31:0] pc_next;
    logic        ack_ok;

    assign pc_next        = pc + 32'(PC_STEP);
    assign ack_ok         = req & imem.imem_ack;
    assign imem.imem_req  = req;
    assign imem.imem_addr = pc;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= FETCH;
            req             <= 1'b0;
            pc              <= RESET_PC;
            target          <= '0;
            hold_word       <= '0;
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
        end else if (branch_taken) begin
            pc_out          <= '0;
            instruction_out <= '0;
            valid_out       <= 1'b0;
            req             <= 1'b1;
            case (state)
                FETCH: begin
                    // An unacked request cannot be withdrawn; wait out its ack in DISCARD.
                    if (ack_ok) begin
                        pc <= branch_addr;
                    end else begin
                        target <= branch_addr;
                        state  <= DISCARD;
                    end
                end
                HOLD: begin
                    pc    <= branch_addr;
                    state <= FETCH;
                end
                DISCARD: begin
                    if (ack_ok) begin
                        pc    <= branch_addr;
                        state <= FETCH;
                    end else begin
                        target <= branch_addr;
                    end
                end
                default: state <= FETCH;
            endcase
        end else begin
            case (state)
                FETCH: begin
                    req <= 1'b1;
                    if (ack_ok) begin
                        pc <= pc_next;
                        if (freeze) begin
                            hold_word <= imem.imem_rdata;
                            req       <= 1'b0;
                            state     <= HOLD;
                        end else begin
                            pc_out          <= pc_next;
                            instruction_out <= imem.imem_rdata;
                            valid_out       <= 1'b1;
                        end
                    end
                end
                HOLD: begin
                    // pc already advanced at capture, so it is the buffered word's pc_out.
                    if (!freeze) begin
                        pc_out          <= pc;
                        instruction_out <= hold_word;
                        valid_out       <= 1'b1;
                        req             <= 1'b1;
                        state           <= FETCH;
                    end
                end
                DISCARD: begin
                    if (ack_ok) begin
                        pc    <= target;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef IF_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_count <= '0;
            stall_count <= '0;
        end else begin
            if (state == FETCH && ack_ok && !branch_taken) fetch_count <= fetch_count + 32'd1;
            if (freeze && valid_out) stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed cycle table, async-reset-in-DISCARD sequence, then random traffic
// checked against a queue-based transaction model.
module tb_if_stage;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        freeze = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_addr = '0;
    logic [31:0] pc_out;
    logic [31:0] instruction_out;
    logic        valid_out;
`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_count;
    logic [31:0] stall_count;
`endif

    if_stage_if imem();

    if_stage #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .freeze          (freeze),
        .branch_taken    (branch_taken),
        .branch_addr     (branch_addr),
        .imem            (imem),
        .pc_out          (pc_out),
        .instruction_out (instruction_out),
        .valid_out       (valid_out)
`ifdef IF_PERF_CNT_EN
        ,
        .fetch_count     (fetch_count),
        .stall_count     (stall_count)
`endif
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Directed table: expected outputs seen during the cycle, then inputs applied for its edge.
    typedef struct {
        logic        req;
        logic [31:0] addr;
        logic [31:0] pco;
        logic        v;
        logic        ack;
        logic        fr;
        logic        br;
        logic [31:0] ba;
    } vec_t;

    vec_t tbl[28];

    function automatic vec_t row(input logic req, input logic [31:0] addr, input logic [31:0] pco,
                                 input logic v, input logic ack, input logic fr, input logic br,
                                 input logic [31:0] ba);
        vec_t r;
        r.req = req; r.addr = addr; r.pco = pco; r.v = v;
        r.ack = ack; r.fr = fr; r.br = br; r.ba = ba;
        return r;
    endfunction

    // Transaction-level reference: request address, orphan flag, hold queue, IF/ID slot.
    logic [31:0] m_pc, m_target, m_pco, m_ins, m_fc, m_sc;
    logic        m_req, m_orphan, m_v;
    logic [31:0] hold_q[$];

    task automatic model_reset();
        m_pc = 32'h0; m_target = '0; m_req = 1'b0; m_orphan = 1'b0;
        m_pco = '0; m_ins = '0; m_v = 1'b0; m_fc = '0; m_sc = '0;
        hold_q.delete();
    endtask

    task automatic model_step(input logic fr, input logic br, input logic [31:0] ba,
                              input logic ack, input logic [31:0] rd);
        logic acc;
        acc = m_req && ack;
        if (m_v && fr) m_sc++;
        if (br) begin
            m_pco = '0; m_ins = '0; m_v = 1'b0;
            if (hold_q.size() != 0) begin
                hold_q.delete();
                m_pc = ba;
            end else if (m_orphan) begin
                if (acc) begin m_orphan = 1'b0; m_pc = ba; end
                else m_target = ba;
            end else if (acc) begin
                m_pc = ba;
            end else begin
                m_orphan = 1'b1; m_target = ba;
            end
            m_req = 1'b1;
        end else if (hold_q.size() != 0) begin
            if (!fr) begin
                m_pco = m_pc; m_ins = hold_q.pop_front(); m_v = 1'b1; m_req = 1'b1;
            end
        end else if (acc && m_orphan) begin
            m_orphan = 1'b0; m_pc = m_target;
        end else if (acc) begin
            m_fc++;
            m_pc = m_pc + 32'd4;
            if (fr) begin
                hold_q.push_back(rd); m_req = 1'b0;
            end else begin
                m_pco = m_pc; m_ins = rd; m_v = 1'b1;
            end
        end else begin
            m_req = 1'b1;
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, " req"}, imem.imem_req, 32'd0);
        check({tag, " addr"}, imem.imem_addr, 32'd0);
        check({tag, " pc_out"}, pc_out, 32'd0);
        check({tag, " instr"}, instruction_out, 32'd0);
        check({tag, " valid"}, valid_out, 32'd0);
`ifdef IF_PERF_CNT_EN
        check({tag, " fetch_count"}, fetch_count, 32'd0);
        check({tag, " stall_count"}, stall_count, 32'd0);
`endif
    endtask

    initial begin
        logic        r_fr, r_br, r_ack;
        logic [31:0] r_ba, r_rd;

        imem.imem_ack   = 1'b0;
        imem.imem_rdata = '0;

        //         req addr      pco       v  ack fr br ba
        tbl[0]  = row(0, 32'h000, 32'h000, 0, 1, 0, 0, 32'h0);
        tbl[1]  = row(1, 32'h000, 32'h000, 0, 1, 0, 0, 32'h0);
        tbl[2]  = row(1, 32'h004, 32'h004, 1, 1, 0, 0, 32'h0);
        tbl[3]  = row(1, 32'h008, 32'h008, 1, 1, 0, 0, 32'h0);
        tbl[4]  = row(1, 32'h00C, 32'h00C, 1, 1, 0, 0, 32'h0);
        tbl[5]  = row(1, 32'h010, 32'h010, 1, 0, 0, 0, 32'h0);
        tbl[6]  = row(1, 32'h010, 32'h010, 1, 0, 0, 0, 32'h0);
        tbl[7]  = row(1, 32'h010, 32'h010, 1, 0, 0, 0, 32'h0);
        tbl[8]  = row(1, 32'h010, 32'h010, 1, 1, 0, 0, 32'h0);
        tbl[9]  = row(1, 32'h014, 32'h014, 1, 1, 1, 0, 32'h0);
        tbl[10] = row(0, 32'h000, 32'h014, 1, 0, 1, 0, 32'h0);
        tbl[11] = row(0, 32'h000, 32'h014, 1, 1, 1, 0, 32'h0);
        tbl[12] = row(0, 32'h000, 32'h014, 1, 0, 1, 0, 32'h0);
        tbl[13] = row(0, 32'h000, 32'h014, 1, 0, 0, 0, 32'h0);
        tbl[14] = row(1, 32'h018, 32'h018, 1, 1, 0, 0, 32'h0);
        tbl[15] = row(1, 32'h01C, 32'h01C, 1, 1, 0, 0, 32'h0);
        tbl[16] = row(1, 32'h020, 32'h020, 1, 0, 0, 1, 32'h100);
        tbl[17] = row(1, 32'h020, 32'h000, 0, 0, 0, 0, 32'h0);
        tbl[18] = row(1, 32'h020, 32'h000, 0, 1, 0, 0, 32'h0);
        tbl[19] = row(1, 32'h100, 32'h000, 0, 1, 0, 0, 32'h0);
        tbl[20] = row(1, 32'h104, 32'h104, 1, 1, 1, 1, 32'h200);
        tbl[21] = row(1, 32'h200, 32'h000, 0, 1, 1, 0, 32'h0);
        tbl[22] = row(0, 32'h000, 32'h000, 0, 0, 1, 1, 32'h300);
        tbl[23] = row(1, 32'h300, 32'h000, 0, 0, 0, 1, 32'h400);
        tbl[24] = row(1, 32'h300, 32'h000, 0, 0, 0, 1, 32'h500);
        tbl[25] = row(1, 32'h300, 32'h000, 0, 1, 0, 0, 32'h0);
        tbl[26] = row(1, 32'h500, 32'h000, 0, 1, 0, 0, 32'h0);
        tbl[27] = row(1, 32'h504, 32'h504, 1, 0, 0, 1, 32'h600);

        repeat (2) @(negedge clk);
        check_zero("reset");
        rst = 1'b1;

        for (int i = 0; i < 28; i++) begin
            check($sformatf("row%0d req", i), imem.imem_req, 32'(tbl[i].req));
            if (tbl[i].req) check($sformatf("row%0d addr", i), imem.imem_addr, tbl[i].addr);
            check($sformatf("row%0d pc_out", i), pc_out, tbl[i].pco);
            check($sformatf("row%0d valid", i), valid_out, 32'(tbl[i].v));
            check($sformatf("row%0d instr", i), instruction_out,
                  tbl[i].v ? mem_word(tbl[i].pco - 32'd4) : 32'd0);
            imem.imem_ack   = tbl[i].ack;
            imem.imem_rdata = mem_word(tbl[i].addr);
            freeze          = tbl[i].fr;
            branch_taken    = tbl[i].br;
            branch_addr     = tbl[i].ba;
            @(negedge clk);
        end

        // Now in DISCARD holding the orphaned request to 0x504.
        check("discard req", imem.imem_req, 32'd1);
        check("discard addr", imem.imem_addr, 32'h504);
        check("discard valid", valid_out, 32'd0);
`ifdef IF_PERF_CNT_EN
        check("table fetch_count", fetch_count, 32'd11);
        check("table stall_count", stall_count, 32'd5);
`endif
        imem.imem_ack = 1'b0; freeze = 1'b0; branch_taken = 1'b0;
        #2 rst = 1'b0;
        #1 check_zero("mid-discard reset");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("restart req", imem.imem_req, 32'd1);
        check("restart addr", imem.imem_addr, 32'h0);

        // Random traffic against the reference model.
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            check("rnd req", imem.imem_req, 32'(m_req));
            if (m_req) check("rnd addr", imem.imem_addr, m_pc);
            check("rnd pc_out", pc_out, m_pco);
            check("rnd instr", instruction_out, m_ins);
            check("rnd valid", valid_out, 32'(m_v));
`ifdef IF_PERF_CNT_EN
            check("rnd fetch_count", fetch_count, m_fc);
            check("rnd stall_count", stall_count, m_sc);
`endif
            if ($urandom_range(0, 249) == 0) begin
                rst = 1'b0;
                #1 check_zero("rnd reset");
                model_reset();
                #1 rst = 1'b1;
            end
            r_fr  = ($urandom_range(0, 3) == 0);
            r_br  = ($urandom_range(0, 9) == 0);
            r_ba  = ($urandom_range(0, 5) == 0) ? 32'hFFFF_FFF8 : ($urandom() & 32'hFFFF_FFFC);
            r_ack = 1'($urandom_range(0, 1));
            r_rd  = m_req ? mem_word(m_pc) : $urandom();
            imem.imem_ack   = r_ack;
            imem.imem_rdata = r_rd;
            freeze          = r_fr;
            branch_taken    = r_br;
            branch_addr     = r_ba;
            model_step(r_fr, r_br, r_ba, r_ack, r_rd);
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
